// File: rtl/lsu_byte_sequencer.sv
// Byte-lane load/store sequencer in front of a 32K x 8 dual-port RAM.
// Optional build macro LSU_ALIGN_CHECK_EN rejects misaligned half/word accesses with rsp_err.
module lsu_byte_sequencer #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [7:0]        ram_wdata_a,
  output logic [7:0]        ram_wdata_b,
  output logic              ram_we_a,
  output logic              ram_we_b,
  input  logic [7:0]        ram_rdata_a,
  input  logic [7:0]        ram_rdata_b
);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP0, CAP1} state_t;

  state_t              state, state_nxt;
  logic                accept, illegal;
  logic [ADDR_W-1:0]   addr_p0;
  logic                we_p0;
  logic [1:0]          size_p0;
  logic                zext_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic [15:0]         lo_p1;
  logic                rsp_valid_nxt, rsp_err_nxt;
  logic [DATA_W-1:0]   rsp_rdata_nxt;
  logic                unused_addr_hi;

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                               input logic [1:0] size,
                                               input logic zext);
    logic [DATA_W-1:0] res;
    case (size)
      2'b00:   res = zext ? {{(DATA_W-8){1'b0}}, raw[7:0]}
                          : {{(DATA_W-8){raw[7]}}, raw[7:0]};
      2'b01:   res = zext ? {{(DATA_W-16){1'b0}}, raw[15:0]}
                          : {{(DATA_W-16){raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  assign unused_addr_hi = ^req_addr[31:ADDR_W];
  assign req_ready      = (state == IDLE);
  assign accept         = req_valid && req_ready;

`ifdef LSU_ALIGN_CHECK_EN
  assign illegal = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
  assign illegal = (req_size == 2'b11);
`endif

  // p0: request capture; p1: low lanes of a word load held until the high lanes return
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= req_addr[ADDR_W-1:0];
      we_p0    <= req_we;
      size_p0  <= req_size;
      zext_p0  <= req_unsigned;
      wdata_p0 <= req_wdata;
    end
    if (state == ACC1) lo_p1 <= {ram_rdata_b, ram_rdata_a};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = 1'b0;
    rsp_rdata_nxt = '0;
    case (state)
      IDLE: begin
        if (accept && illegal) begin
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
        end else if (accept) begin
          state_nxt = ACC0;
        end
      end
      ACC0: begin
        if (size_p0 == 2'b10) begin
          state_nxt = ACC1;
        end else if (we_p0) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b1;
        end else begin
          state_nxt = CAP0;
        end
      end
      ACC1: begin
        if (we_p0) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b1;
        end else begin
          state_nxt = CAP1;
        end
      end
      CAP0: begin
        state_nxt     = IDLE;
        rsp_valid_nxt = 1'b1;
        rsp_rdata_nxt = extend({16'h0000, ram_rdata_b, ram_rdata_a}, size_p0, zext_p0);
      end
      CAP1: begin
        state_nxt     = IDLE;
        rsp_valid_nxt = 1'b1;
        rsp_rdata_nxt = {ram_rdata_b, ram_rdata_a, lo_p1};
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Port B carries the odd lane; it is idle for byte accesses
  always_comb begin
    ram_addr_a  = '0;
    ram_addr_b  = '0;
    ram_wdata_a = 8'h00;
    ram_wdata_b = 8'h00;
    ram_we_a    = 1'b0;
    ram_we_b    = 1'b0;
    if (state == ACC0) begin
      ram_addr_a  = addr_p0;
      ram_addr_b  = addr_p0 + ADDR_W'(1);
      ram_wdata_a = wdata_p0[7:0];
      ram_wdata_b = wdata_p0[15:8];
      ram_we_a    = we_p0;
      ram_we_b    = we_p0 && (size_p0 != 2'b00);
    end else if (state == ACC1) begin
      ram_addr_a  = addr_p0 + ADDR_W'(2);
      ram_addr_b  = addr_p0 + ADDR_W'(3);
      ram_wdata_a = wdata_p0[23:16];
      ram_wdata_b = wdata_p0[31:24];
      ram_we_a    = we_p0;
      ram_we_b    = we_p0;
    end
  end

endmodule
